booth_r8_decoder: RTL and testbench

BOOTH_R8_DECODER -- requirements
Module: booth_r8_decoder

---
 rtl/booth_r8_decoder.sv | 128 ++++++++++++
 tb/tb_booth_r8_decoder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/booth_r8_decoder.sv
// Radix-8 Booth digit decoder: folds GROUP_CNT signed-digit select groups, MSB group first,
// into the unsigned operand they encode, flagging illegal codes and out-of-range results.
module booth_r8_decoder #(
    parameter int WIDTH     = 16,
    parameter int GROUP_CNT = (WIDTH >> 2) + 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [GROUP_CNT-1:0] s,
    input  logic [GROUP_CNT-1:0] d,
    input  logic [GROUP_CNT-1:0] t,
    input  logic [GROUP_CNT-1:0] q,
    input  logic [GROUP_CNT-1:0] n,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     mx_out,
    output logic                 code_err,
    output logic                 range_err,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [15:0]          err_count
);
    localparam int ACC_W = WIDTH + 4;
    localparam int CNT_W = (GROUP_CNT > 1) ? $clog2(GROUP_CNT) : 1;
    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'((1 << WIDTH) - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    // Digit value of one group; illegal (multi-hot) selects contribute nothing.
    function automatic logic signed [ACC_W-1:0] booth_digit(input logic [3:0] sel, input logic neg);
        logic signed [3:0] m;
        case (sel)
            4'b0001: m = 4'sd1;
            4'b0010: m = 4'sd2;
            4'b0100: m = 4'sd3;
            4'b1000: m = 4'sd4;
            default: m = 4'sd0;
        endcase
        return neg ? ACC_W'(-m) : ACC_W'(m);
    endfunction

    function automatic logic code_illegal(input logic [3:0] sel);
        return $countones(sel) > 1;
    endfunction

    function automatic logic out_of_range(input logic signed [ACC_W-1:0] v);
        return (v < 0) || (v > ACC_MAX);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t                  state_q;
    logic [GROUP_CNT-1:0]    s_q, d_q, t_q, q_q, n_q;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q;
    logic [WIDTH-1:0]        mx_q;
    logic                    code_err_q, range_err_q, out_valid_q, in_ready_q;
    logic [15:0]             err_cnt_q;
    logic [3:0]              sel_d;
    logic                    illegal_d;

    always_comb begin
        sel_d     = {q_q[cnt_q], t_q[cnt_q], d_q[cnt_q], s_q[cnt_q]};
        illegal_d = code_illegal(sel_d);
        acc_d     = (acc_q <<< 3) + booth_digit(sel_d, n_q[cnt_q]);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            mx_q        <= '0;
            code_err_q  <= 1'b0;
            range_err_q <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            err_cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        s_q        <= s;
                        d_q        <= d;
                        t_q        <= t;
                        q_q        <= q;
                        n_q        <= n;
                        acc_q      <= '0;
                        code_err_q <= 1'b0;
                        cnt_q      <= CNT_W'(GROUP_CNT - 1);
                        in_ready_q <= 1'b0;
                        state_q    <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc_q      <= acc_d;
                    code_err_q <= code_err_q | illegal_d;
                    cnt_q      <= cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        mx_q        <= acc_d[WIDTH-1:0];
                        range_err_q <= out_of_range(acc_d);
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        if (code_err_q || range_err_q)
                            err_cnt_q <= sat_inc(err_cnt_q);
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign mx_out    = mx_q;
    assign code_err  = code_err_q;
    assign range_err = range_err_q;
    assign out_valid = out_valid_q;
    assign err_count = err_cnt_q;
endmodule

// File: tb/tb_booth_r8_decoder.sv
// Scoreboard bench for booth_r8_decoder: directed Booth code vectors plus an encoder-driven sweep.
module tb_booth_r8_decoder;
    logic        CLK = 1'b0;
    logic        RST;
    logic [5:0]  s, d, t, q, n;
    logic        in_valid, in_ready, code_err, range_err, out_valid, out_ready;
    logic [15:0] mx_out, err_count;

    typedef struct packed {
        logic [15:0] mx;
        logic        ce;
        logic        re;
    } exp_t;

    exp_t sbq[$];
    int   tests  = 0;
    int   failed = 0;

    booth_r8_decoder #(.WIDTH(16)) dut (
        .CLK(CLK), .RST(RST), .s(s), .d(d), .t(t), .q(q), .n(n),
        .in_valid(in_valid), .in_ready(in_ready), .mx_out(mx_out),
        .code_err(code_err), .range_err(range_err), .out_valid(out_valid),
        .out_ready(out_ready), .err_count(err_count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: one compare per accepted result.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (!RST && out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("mx_out", {16'd0, mx_out}, {16'd0, e.mx});
                    chk("code_err", {31'd0, code_err}, {31'd0, e.ce});
                    chk("range_err", {31'd0, range_err}, {31'd0, e.re});
                end
            end
        end
    end

    // Reference radix-8 Booth encoder of an unsigned 16-bit value.
    task automatic encode(input logic [15:0] x, output logic [5:0] es, ed, et, eq, en);
        logic [18:0] b;
        int dig, mag;
        b  = {2'b00, x, 1'b0};
        es = '0; ed = '0; et = '0; eq = '0; en = '0;
        for (int g = 0; g < 6; g++) begin
            dig = -4 * int'(b[3*g+3]) + 2 * int'(b[3*g+2]) + int'(b[3*g+1]) + int'(b[3*g]);
            mag = (dig < 0) ? -dig : dig;
            en[g] = (dig < 0);
            case (mag)
                1: es[g] = 1'b1;
                2: ed[g] = 1'b1;
                3: et[g] = 1'b1;
                4: eq[g] = 1'b1;
                default: ;
            endcase
        end
    endtask

    task automatic drive(input logic [5:0] vs, vd, vt, vq, vn, input bit push,
                         input logic [15:0] emx, input logic ece, input logic ere);
        int w = 0;
        while (!in_ready && w < 50) begin
            @(posedge CLK); #1; w++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
        s = vs; d = vd; t = vt; q = vq; n = vn; in_valid = 1'b1;
        if (push) sbq.push_back('{mx: emx, ce: ece, re: ere});
        @(posedge CLK); #1;
        in_valid = 1'b0;
        s = 6'($urandom); d = 6'($urandom); t = 6'($urandom); q = 6'($urandom); n = 6'($urandom);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(posedge CLK); #1; lat++;
        end while (!out_valid && lat < 20);
        if (!out_valid) chk("out_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_hand(input string name, input logic [5:0] vs, vd, vt, vq, vn,
                            input logic [15:0] emx, input logic ece, input logic ere);
        int lat;
        drive(vs, vd, vt, vq, vn, 1'b1, emx, ece, ere);
        wait_done(lat);
        chk({name, "_latency"}, lat, 32'd6);
        @(posedge CLK); #1;
    endtask

    initial begin
        logic [5:0]  es, ed, et, eq, en;
        logic [15:0] x, hold_mx;
        logic        hold_ce, hold_re;
        bit          seen;
        int          lat;

        RST = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        s = '0; d = '0; t = '0; q = '0; n = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mx_out", {16'd0, mx_out}, 32'd0);
        chk("rst_errs", {30'd0, code_err, range_err}, 32'd0);
        chk("rst_err_count", {16'd0, err_count}, 32'd0);
        RST = 1'b0;
        @(posedge CLK); #1;

        run_hand("zero",  6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 16'h0000, 1'b0, 1'b0);
        run_hand("seven", 6'h03, 6'h00, 6'h00, 6'h00, 6'h01, 16'h0007, 1'b0, 1'b0);
        run_hand("ffff",  6'h01, 6'h20, 6'h00, 6'h00, 6'h01, 16'hFFFF, 1'b0, 1'b0);
        // 4*4096 - 2*512 + 3*8 + 4 = 15388
        run_hand("mixed", 6'h00, 6'h08, 6'h02, 6'h11, 6'h08, 16'h3C1C, 1'b0, 1'b0);
        run_hand("n_only", 6'h00, 6'h00, 6'h00, 6'h00, 6'h3F, 16'h0000, 1'b0, 1'b0);

        for (int i = 0; i < 10000; i++) begin
            x = 16'($urandom);
            if (i == 0) x = 16'h0000;
            if (i == 1) x = 16'hFFFF;
            if (i == 2) x = 16'h8000;
            encode(x, es, ed, et, eq, en);
            drive(es, ed, et, eq, en, 1'b1, x, 1'b0, 1'b0);
            wait_done(lat);
        end
        @(posedge CLK); #1;
        chk("sweep_err_count", {16'd0, err_count}, 32'd0);

        run_hand("code_err", 6'h04, 6'h04, 6'h00, 6'h00, 6'h00, 16'h0000, 1'b1, 1'b0);
        chk("err_count_1", {16'd0, err_count}, 32'd1);
        run_hand("range_hi", 6'h00, 6'h00, 6'h00, 6'h20, 6'h00, 16'h0000, 1'b0, 1'b1);
        chk("err_count_2", {16'd0, err_count}, 32'd2);
        run_hand("range_neg", 6'h01, 6'h00, 6'h00, 6'h00, 6'h01, 16'hFFFF, 1'b0, 1'b1);
        chk("err_count_3", {16'd0, err_count}, 32'd3);

        // Back-pressure: hold DONE for 5 cycles and poke in_valid meanwhile.
        out_ready = 1'b0;
        drive(6'h03, 6'h00, 6'h00, 6'h00, 6'h01, 1'b1, 16'h0007, 1'b0, 1'b0);
        wait_done(lat);
        hold_mx = mx_out; hold_ce = code_err; hold_re = range_err;
        for (int i = 0; i < 5; i++) begin
            chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            chk("stall_mx_out", {16'd0, mx_out}, {16'd0, hold_mx});
            chk("stall_errs", {30'd0, code_err, range_err}, {30'd0, hold_ce, hold_re});
            if (i == 1) begin
                s = 6'h00; d = 6'h00; t = 6'h00; q = 6'h20; n = 6'h00;
            end
            in_valid = (i == 1);
            @(posedge CLK); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge CLK); #1;
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
        chk("release_out_valid", {31'd0, out_valid}, 32'd0);
        seen = 1'b0;
        repeat (12) begin
            @(posedge CLK); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("ignored_in_valid", {31'd0, seen}, 32'd0);
        chk("stall_err_count", {16'd0, err_count}, 32'd3);

        // Reset three cycles into ACCUM of an operand with an illegal code.
        drive(6'h20, 6'h20, 6'h00, 6'h00, 6'h00, 1'b0, 16'h0000, 1'b0, 1'b0);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_mx_out", {16'd0, mx_out}, 32'd0);
        chk("abort_errs", {30'd0, code_err, range_err}, 32'd0);
        chk("abort_err_count", {16'd0, err_count}, 32'd0);
        seen = 1'b0;
        repeat (10) begin
            @(posedge CLK); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_out_valid", {31'd0, seen}, 32'd0);

        // Saturation of the error counter.
        force dut.err_cnt_q = 16'hFFFF;
        @(posedge CLK); #1;
        release dut.err_cnt_q;
        chk("forced_err_count", {16'd0, err_count}, 32'h0000FFFF);
        run_hand("sat_code_err", 6'h01, 6'h01, 6'h00, 6'h00, 6'h00, 16'h0000, 1'b1, 1'b0);
        chk("sat_err_count", {16'd0, err_count}, 32'h0000FFFF);

        repeat (3) @(posedge CLK);
        #1;
        chk("scoreboard_empty", sbq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
